// File: rtl/stopwatch_record_regfile_57_if.sv
// stopwatch_record_regfile_57_if: lap capture, read request and read-data bus of the lap-record store.
interface stopwatch_record_regfile_57_if #(parameter int W = 7);
   logic         record_e_57;
   logic         clear_57;
   logic [W-1:0] stopwatch_sec_57;
   logic [W-1:0] stopwatch_min_57;
   logic [W-1:0] stopwatch_hour_57;
   logic         read_e_57;
   logic [2:0]   read_addr_57;
   logic [W-1:0] record_stopwatch_sec_57;
   logic [W-1:0] record_stopwatch_min_57;
   logic [W-1:0] record_stopwatch_hour_57;
   logic         record_valid_57;
   logic [3:0]   record_count_57;
   logic         full_57;
   modport master (
      output record_e_57, clear_57, stopwatch_sec_57, stopwatch_min_57, stopwatch_hour_57,
             read_e_57, read_addr_57,
      input  record_stopwatch_sec_57, record_stopwatch_min_57, record_stopwatch_hour_57,
             record_valid_57, record_count_57, full_57
   );
   modport slave (
      input  record_e_57, clear_57, stopwatch_sec_57, stopwatch_min_57, stopwatch_hour_57,
             read_e_57, read_addr_57,
      output record_stopwatch_sec_57, record_stopwatch_min_57, record_stopwatch_hour_57,
             record_valid_57, record_count_57, full_57
   );
endinterface

// File: rtl/stopwatch_record_regfile_57.sv
// stopwatch_record_regfile_57: DEPTH-entry ring of stopwatch laps with registered logical-index reads.
// Define STOPWATCH_RECORD_NO_OVERWRITE_EN to drop laps when full instead of overwriting the oldest.
module stopwatch_record_regfile_57 #(
   parameter int DEPTH = 5,
   parameter int W     = 7
) (
   input logic                          clk_50m_57,
   input logic                          rst_n_57,
   stopwatch_record_regfile_57_if.slave bus
);
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam logic [2:0] LAST_C  = 3'(DEPTH - 1);
   logic [3*W-1:0] mem_q [DEPTH];
   logic [3*W-1:0] mem_d [DEPTH];
   logic [3*W-1:0] rd_q, rd_d;
   logic           valid_q, valid_d;
   logic [2:0]     wp_q, wp_d;
   logic [3:0]     count_q, count_d;
   logic           full, hit, wr;
   logic [2:0]     oldest, phys;
   logic [3:0]     sum;
   always_comb begin
      full = count_q == DEPTH_C;
`ifdef STOPWATCH_RECORD_NO_OVERWRITE_EN
      oldest = '0;
      wr     = bus.record_e_57 && !full;
`else
      oldest = full ? wp_q : '0;
      wr     = bus.record_e_57;
`endif
      // addr < count <= DEPTH keeps sum below 2*DEPTH, so one subtraction is a full mod
      sum     = {1'b0, oldest} + {1'b0, bus.read_addr_57};
      phys    = sum >= DEPTH_C ? 3'(sum - DEPTH_C) : sum[2:0];
      hit     = {1'b0, bus.read_addr_57} < count_q;
      mem_d   = mem_q;
      wp_d    = wp_q;
      count_d = count_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      if (bus.clear_57) begin
         mem_d   = '{default: '0};
         wp_d    = '0;
         count_d = '0;
         rd_d    = '0;
         valid_d = 1'b0;
      end else begin
         if (bus.read_e_57) begin
            rd_d    = hit ? mem_q[phys] : '0;
            valid_d = hit;
         end
         if (wr) begin
            mem_d[wp_q] = {bus.stopwatch_hour_57, bus.stopwatch_min_57, bus.stopwatch_sec_57};
            wp_d        = wp_q == LAST_C ? '0 : wp_q + 3'd1;
            count_d     = full ? count_q : count_q + 4'd1;
         end
      end
   end
   always_ff @(posedge clk_50m_57) begin
      if (!rst_n_57) begin
         mem_q   <= '{default: '0};
         wp_q    <= '0;
         count_q <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wp_q    <= wp_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
      end
   end
   assign {bus.record_stopwatch_hour_57, bus.record_stopwatch_min_57, bus.record_stopwatch_sec_57} = rd_q;
   assign bus.record_valid_57 = valid_q;
   assign bus.record_count_57 = count_q;
   assign bus.full_57         = full;
endmodule

// File: tb/tb_stopwatch_record_regfile_57.sv
// tb_stopwatch_record_regfile_57: directed laps and reads; expected responses queued and checked by a monitor.
module tb_stopwatch_record_regfile_57;
   typedef struct packed {
      logic       v;
      logic [6:0] h;
      logic [6:0] m;
      logic [6:0] s;
      logic [3:0] c;
      logic       f;
   } item_t;
`ifdef STOPWATCH_RECORD_NO_OVERWRITE_EN
   localparam int BASE = 1;
`else
   localparam int BASE = 3;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic obs = 1'b0;
   logic done = 1'b0;
   int total = 0;
   int pass = 0;
   item_t q[$];
   item_t e, act;
   logic samp;
   stopwatch_record_regfile_57_if #(.W(7)) bus ();
   stopwatch_record_regfile_57 #(.DEPTH(5), .W(7)) dut (
      .clk_50m_57 (clk),
      .rst_n_57   (rst_n),
      .bus        (bus.slave)
   );
   always #10 clk = ~clk;
   task automatic drive(input logic rec, input logic clr, input logic rd, input logic ob,
                        input logic [2:0] a, input logic [6:0] s, input logic [6:0] m, input logic [6:0] h);
      bus.record_e_57       = rec;
      bus.clear_57          = clr;
      bus.read_e_57         = rd;
      obs                   = ob;
      bus.read_addr_57      = a;
      bus.stopwatch_sec_57  = s;
      bus.stopwatch_min_57  = m;
      bus.stopwatch_hour_57 = h;
      @(negedge clk);
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 3'd0, 7'd0, 7'd0, 7'd0);
   endtask
   task automatic lap(input logic [6:0] s, input logic [6:0] m, input logic [6:0] h);
      drive(1, 0, 0, 0, 3'd0, s, m, h);
   endtask
   task automatic expect_(input logic v, input logic [6:0] h, input logic [6:0] m, input logic [6:0] s,
                          input logic [3:0] c, input logic f);
      q.push_back('{v: v, h: h, m: m, s: s, c: c, f: f});
   endtask
   task automatic rd(input logic [2:0] a);
      drive(0, 0, 1, 0, a, 7'd0, 7'd0, 7'd0);
   endtask
   always @(posedge clk) begin
      samp = obs || (rst_n && bus.read_e_57 && !bus.clear_57);
      #1;
      if (samp) begin
         total++;
         act = '{v: bus.record_valid_57, h: bus.record_stopwatch_hour_57, m: bus.record_stopwatch_min_57,
                 s: bus.record_stopwatch_sec_57, c: bus.record_count_57, f: bus.full_57};
         if (q.size() == 0) begin
            $display("FAIL resp%0d: output presented with nothing expected (got %h)", total, act);
         end else begin
            e = q.pop_front();
            if (act === e) pass++;
            else $display("FAIL resp%0d: got v=%b h=%0d m=%0d s=%0d cnt=%0d full=%b, want v=%b h=%0d m=%0d s=%0d cnt=%0d full=%b",
                          total, act.v, act.h, act.m, act.s, act.c, act.f, e.v, e.h, e.m, e.s, e.c, e.f);
         end
      end
      if (done) begin
         total++;
         if (q.size() == 0) pass++;
         else $display("FAIL drain: %0d expected responses never seen, want 0", q.size());
         $display("%0d/%0d checks passed", pass, total);
         $finish;
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      bus.record_e_57 = 0; bus.clear_57 = 0; bus.read_e_57 = 0; bus.read_addr_57 = 0;
      bus.stopwatch_sec_57 = 0; bus.stopwatch_min_57 = 0; bus.stopwatch_hour_57 = 0;
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      expect_(0, 0, 0, 0, 0, 0); rd(3'd0);
      lap(7'd5, 7'd0, 7'd0);
      lap(7'd10, 7'd1, 7'd0);
      lap(7'd3, 7'd2, 7'd1);
      expect_(1, 0, 0, 5, 3, 0);  rd(3'd0);
      expect_(1, 0, 1, 10, 3, 0); rd(3'd1);
      expect_(1, 1, 2, 3, 3, 0);  rd(3'd2);
      expect_(0, 0, 0, 0, 3, 0);  rd(3'd3);
      expect_(0, 0, 0, 0, 0, 0);  drive(1, 1, 1, 1, 3'd0, 7'd9, 7'd9, 7'd9);
      expect_(0, 0, 0, 0, 0, 0);  rd(3'd0);
      for (int i = 1; i <= 7; i++) lap(7'(i), 7'd0, 7'd0);
      for (int i = 0; i < 5; i++) begin
         expect_(1, 0, 0, 7'(BASE + i), 5, 1); rd(3'(i));
      end
      expect_(0, 0, 0, 0, 5, 1); rd(3'd5);
      expect_(0, 0, 0, 0, 5, 1); rd(3'd7);
      drive(0, 1, 0, 0, 3'd0, 7'd0, 7'd0, 7'd0);
      lap(7'd4, 7'd0, 7'd0);
      expect_(1, 0, 0, 4, 2, 0); drive(1, 0, 1, 0, 3'd0, 7'd9, 7'd0, 7'd0);
      expect_(1, 0, 0, 9, 2, 0); rd(3'd1);
      drive(0, 1, 0, 0, 3'd0, 7'd0, 7'd0, 7'd0);
      for (int i = 11; i <= 14; i++) lap(7'(i), 7'd0, 7'd0);
      expect_(1, 0, 0, 11, 4, 0); rd(3'd0);
      rst_n = 1'b0;
      expect_(0, 0, 0, 0, 0, 0); drive(0, 0, 1, 1, 3'd1, 7'd0, 7'd0, 7'd0);
      rst_n = 1'b1;
      expect_(0, 0, 0, 0, 0, 0); rd(3'd0);
      idle();
      idle();
      done = 1'b1;
      idle();
   end
endmodule

// File: doc/stopwatch_record_regfile_57.md
Name: stopwatch_record_regfile_57

Overview:
- Lap-record store that answers the stopwatch record reader's read requests (`read_e_57` / `read_addr_57`).
- Captures the running stopwatch time (sec/min/hour) on each lap pulse into a DEPTH-entry ring buffer, overwriting the oldest entry when full.
- Returns the addressed record, registered, on the `record_stopwatch_*` bus.
- Sits between the stopwatch counter (write side) and the record display path (read side).

Parameters:
- DEPTH, 5, number of lap records held; legal range 1..8, addressed by a 3-bit logical index.
- W, 7, width of each sec/min/hour field.

Ports:
- clk_50m_57  in  1  system clock, 50 MHz
- rst_n_57  in  1  synchronous active-low reset
- record_e_57  in  1  one-cycle pulse: capture current stopwatch time as a new lap
- clear_57  in  1  one-cycle pulse: discard all records
- stopwatch_sec_57  in  W  current stopwatch seconds
- stopwatch_min_57  in  W  current stopwatch minutes
- stopwatch_hour_57  in  W  current stopwatch hours
- read_e_57  in  1  one-cycle read strobe from reader
- read_addr_57  in  3  logical record index; 0 = oldest valid record
- record_stopwatch_sec_57  out  W  read data, seconds
- record_stopwatch_min_57  out  W  read data, minutes
- record_stopwatch_hour_57  out  W  read data, hours
- record_valid_57  out  1  read data corresponds to a stored record
- record_count_57  out  4  number of valid records, 0..DEPTH
- full_57  out  1  record_count_57 == DEPTH

Behaviour:
- Reset (rst_n_57 low at a clk edge):
  - write pointer wp=0, count=0.
  - All storage entries zeroed.
  - All outputs 0.
  - Reset mid-operation discards any in-flight write/read that cycle.
- Storage: DEPTH entries of {hour, min, sec}. wp points at the next slot to write.
- Write, when record_e_57=1 and clear_57=0:
  - entry[wp] <= {stopwatch_hour_57, stopwatch_min_57, stopwatch_sec_57}.
  - wp <= (wp == DEPTH-1) ? 0 : wp+1.
  - count <= min(count+1, DEPTH).
  - When full, this overwrites the oldest record; the oldest index then advances by one.
  - Write takes effect at the edge; record_count_57/full_57 update the same edge.
- Logical-to-physical mapping (computed from pre-edge wp/count):
  - oldest = (count < DEPTH) ? 0 : wp.
  - phys = (oldest + read_addr_57) mod DEPTH.
- Read, when read_e_57=1: one-cycle latency. At the same edge, outputs are loaded as follows:
  - read_addr_57 < count: outputs <= entry[phys], record_valid_57 <= 1.
  - read_addr_57 >= count (including addr > DEPTH-1): outputs <= 0, record_valid_57 <= 0.
- Outputs hold their value between reads. Strobes may arrive back-to-back every cycle.
- Simultaneous read and write: read uses pre-edge storage, wp and count (read-before-write). The new record is not visible until the next read.
- Clear (clear_57=1):
  - wp, count and storage <= 0; outputs and record_valid_57 <= 0.
  - Clear wins over record_e_57 and read_e_57 in the same cycle; both are dropped.
- No handshake back-pressure; every strobe is accepted in its cycle.
- No arithmetic on the W-bit fields: stored and returned verbatim.

Optional Feature:
- Macro: STOPWATCH_RECORD_NO_OVERWRITE_EN
- Defined: record_e_57 while full_57=1 is ignored (storage, wp and count unchanged), and the oldest index stays 0.
- Not defined: ring overwrite as specified above.
- Read, clear and reset behaviour are identical in both builds.

Test Plan:
- Reset, then read_e_57 at addr 0 → next cycle all outputs 0, record_valid_57=0, record_count_57=0.
- Record laps 0:00:05, 0:01:10, 1:02:03, then read addr 0,1,2,3 on consecutive cycles:
  - addr 0..2 return 5/0/0, 10/1/0, 3/2/1 (sec/min/hour), each with valid=1, one cycle after its strobe.
  - addr 3 returns zeros with valid=0.
  - record_count_57=3.
- Record 7 laps with sec=1..7 (DEPTH=5):
  - count=5 and full=1.
  - Reads of addr 0..4 return sec 3,4,5,6,7.
  - With STOPWATCH_RECORD_NO_OVERWRITE_EN defined they return 1,2,3,4,5 instead.
- Same-cycle record_e (sec=9) and read addr 0 with 1 stored record (sec=4):
  - Read returns sec=4.
  - count becomes 2.
  - A following read of addr 1 returns sec=9.
- Same-cycle clear_57, record_e_57 and read_e_57 with 3 records stored → count=0, outputs 0, valid=0; next read of addr 0 returns valid=0.
- Assert rst_n_57 low for one cycle between two reads after 4 records → all state cleared, subsequent read of addr 0 valid=0, count=0.
